// File: rtl/eth_tx_arb_pkg.sv
// Shared types and width helpers for the eth_tx application-port arbiter.
// Holds the FSM state enum, default sizes and derived width localparams.
package eth_tx_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        HEAD,
        DATA
    } state_t;

    localparam int REQ_N_DEF   = 2;
    localparam int DATA_W_DEF  = 16;
    localparam int PKT_LEN_DEF = 16;
    localparam int UDP_CS_DEF  = 16;
    localparam int BLOCK_N_DEF = 8;

    function automatic int len_w(input int data_w);
        return $clog2(data_w / 8 + 1);
    endfunction

    function automatic int last_len_w(input int data_w, input int block_n);
        return $clog2(block_n + data_w / 8 + 1);
    endfunction

    function automatic int grant_w(input int req_n);
        return $clog2(req_n);
    endfunction

    localparam int LEN_W          = len_w(DATA_W_DEF);
    localparam int APP_LAST_LEN_W = last_len_w(DATA_W_DEF, BLOCK_N_DEF);
    localparam int GRANT_W        = grant_w(REQ_N_DEF);

endpackage

// File: rtl/eth_tx_arb_pick.sv
// Combinational rotate-priority picker: first set request at or after ptr,
// wrapping past REQ_N-1. Ports: req (request vector), ptr (highest-priority
// index) -> grant (winner index), any (at least one request).
module eth_tx_arb_pick
    import eth_tx_arb_pkg::*;
#(
    parameter  int REQ_N   = REQ_N_DEF,
    localparam int GNT_WID = grant_w(REQ_N)
) (
    input  logic [REQ_N-1:0]   req,
    input  logic [GNT_WID-1:0] ptr,
    output logic [GNT_WID-1:0] grant,
    output logic               any
);

    int idx;

    // Scan from the farthest candidate back toward ptr so the last hit
    // written is the closest one; no early-exit flag is needed.
    always_comb begin
        grant = '0;
        idx   = 0;
        for (int i = REQ_N - 1; i >= 0; i--) begin
            idx = int'(ptr) + i;
            if (idx >= REQ_N) idx = idx - REQ_N;
            if (req[idx]) grant = GNT_WID'(idx);
        end
    end

    assign any = |req;

endmodule

// File: rtl/eth_tx_arb.sv
// Shares one eth_tx application port between REQ_N packet sources, one
// grant per packet, held until last, cancel or withdraw of early_v.
// Ports: clk, nreset (sync, active-low); req_* per-source app handshake
// (early_v, ready_v, cancel, data, len, pkt_len, cs, last, last_block_next*);
// app_* muxed eth_tx app port; busy_o grant held; grant_id_o granted index.
// Build option: ETH_TX_ARB_STRICT_PRIO_EN selects fixed priority (source 0
// highest) instead of round-robin.
module eth_tx_arb
    import eth_tx_arb_pkg::*;
#(
    parameter  int REQ_N        = REQ_N_DEF,
    parameter  int DATA_W       = DATA_W_DEF,
    parameter  int PKT_LEN_W    = PKT_LEN_DEF,
    parameter  int UDP_CS_W     = UDP_CS_DEF,
    parameter  int BLOCK_N      = BLOCK_N_DEF,
    localparam int LEN_WID      = len_w(DATA_W),
    localparam int LAST_LEN_WID = last_len_w(DATA_W, BLOCK_N),
    localparam int GNT_WID      = grant_w(REQ_N)
) (
    input  logic                          clk,
    input  logic                          nreset,
    input  logic [REQ_N-1:0]              req_early_v_i,
    output logic [REQ_N-1:0]              req_ready_v_o,
    input  logic [REQ_N-1:0]              req_cancel_i,
    input  logic [REQ_N*DATA_W-1:0]       req_data_i,
    input  logic [REQ_N*LEN_WID-1:0]      req_len_i,
    input  logic [REQ_N*PKT_LEN_W-1:0]    req_pkt_len_i,
    input  logic [REQ_N*UDP_CS_W-1:0]     req_cs_i,
    input  logic [REQ_N-1:0]              req_last_i,
    input  logic [REQ_N-1:0]              req_last_block_next_i,
    input  logic [REQ_N*LAST_LEN_WID-1:0] req_last_block_next_len_i,
    output logic                          app_early_v_o,
    input  logic                          app_ready_v_i,
    output logic                          app_cancel_o,
    output logic [DATA_W-1:0]             app_data_o,
    output logic [LEN_WID-1:0]            app_len_o,
    output logic [PKT_LEN_W-1:0]          app_pkt_len_o,
    output logic [UDP_CS_W-1:0]           app_cs_o,
    output logic                          app_last_o,
    output logic                          app_last_block_next_o,
    output logic [LAST_LEN_WID-1:0]       app_last_block_next_len_o,
    output logic                          busy_o,
    output logic [GNT_WID-1:0]            grant_id_o
);

    state_t               state_q, state_d;
    logic [GNT_WID-1:0]   grant_q, grant_d;
    logic [GNT_WID-1:0]   ptr_q, ptr_d, ptr_use, ptr_next;
    logic [GNT_WID-1:0]   pick_id;
    logic                 pick_any;
    logic                 release_g;
    logic                 g_early, g_cancel, g_last;

    assign g_early  = req_early_v_i[grant_q];
    assign g_cancel = req_cancel_i[grant_q];
    assign g_last   = req_last_i[grant_q];

    assign ptr_next = (int'(grant_q) == REQ_N - 1)
                    ? '0 : grant_q + GNT_WID'(1);

`ifdef ETH_TX_ARB_STRICT_PRIO_EN
    assign ptr_use = '0;
    assign ptr_d   = '0;
`else
    assign ptr_use = ptr_q;
    assign ptr_d   = release_g ? ptr_next : ptr_q;
`endif

    eth_tx_arb_pick #(
        .REQ_N (REQ_N)
    ) u_pick (
        .req   (req_early_v_i),
        .ptr   (ptr_use),
        .grant (pick_id),
        .any   (pick_any)
    );

    always_ff @(posedge clk) begin
        if (!nreset) begin
            state_q <= IDLE;
            grant_q <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
        end
    end

    // Cancel is checked ahead of last/ready so it always wins.
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        release_g = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (pick_any) begin
                    state_d = HEAD;
                    grant_d = pick_id;
                end
            end
            HEAD: begin
                if (g_cancel || !g_early) begin
                    state_d   = IDLE;
                    release_g = 1'b1;
                end else if (app_ready_v_i) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (g_cancel || g_last) begin
                    state_d   = IDLE;
                    release_g = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_ready_v_o             = '0;
        app_early_v_o             = 1'b0;
        app_cancel_o              = 1'b0;
        app_data_o                = '0;
        app_len_o                 = '0;
        app_pkt_len_o             = '0;
        app_cs_o                  = '0;
        app_last_o                = 1'b0;
        app_last_block_next_o     = 1'b0;
        app_last_block_next_len_o = '0;
        unique case (state_q)
            HEAD: begin
                app_early_v_o          = g_early;
                app_pkt_len_o          =
                    req_pkt_len_i[grant_q*PKT_LEN_W +: PKT_LEN_W];
                req_ready_v_o[grant_q] = app_ready_v_i;
                app_cancel_o           = g_cancel;
            end
            DATA: begin
                app_cancel_o          = g_cancel;
                app_data_o            =
                    req_data_i[grant_q*DATA_W +: DATA_W];
                app_len_o             =
                    req_len_i[grant_q*LEN_WID +: LEN_WID];
                app_cs_o              =
                    req_cs_i[grant_q*UDP_CS_W +: UDP_CS_W];
                app_last_o            = g_last;
                app_last_block_next_o = req_last_block_next_i[grant_q];
                app_last_block_next_len_o =
                    req_last_block_next_len_i[grant_q*LAST_LEN_WID +: LAST_LEN_WID];
            end
            default: ;
        endcase
    end

    assign busy_o     = (state_q != IDLE);
    assign grant_id_o = grant_q;

endmodule

// File: tb/tb_eth_tx_arb.sv
// Self-checking bench for eth_tx_arb: per-cycle vector table plus a beat
// scoreboard, with a hand-written mid-packet reset sequence.
module tb_eth_tx_arb;

    typedef struct {
        logic [1:0] early;
        logic       ready;
        logic [1:0] cancel;
        logic [1:0] last;
        logic [1:0] l0;
        logic [1:0] l1;
        logic       eb;
        logic       eg;
        logic       ee;
        logic [1:0] er;
        logic       ec;
        int         fwd;
    } vec_t;

    typedef struct {
        logic [15:0] data;
        logic [1:0]  len;
        logic [15:0] cs;
        logic        last;
        logic        lbn;
        logic [3:0]  lbl;
    } beat_t;

    logic        clk = 1'b0;
    logic        nreset;
    logic [1:0]  req_early_v, req_ready_v, req_cancel, req_last, req_lbn;
    logic [31:0] req_data, req_pkt_len, req_cs;
    logic [3:0]  req_len;
    logic [7:0]  req_lbl;
    logic        app_early_v, app_ready_v, app_cancel, app_last, app_lbn;
    logic [15:0] app_data, app_pkt_len, app_cs;
    logic [1:0]  app_len;
    logic [3:0]  app_lbl;
    logic        busy;
    logic [0:0]  grant_id;

    vec_t  vecs[$];
    beat_t sb[$];
    int    n_chk = 0;
    int    n_fail = 0;
    int    mark;

    always #5 clk = ~clk;

    eth_tx_arb dut (
        .clk                       (clk),
        .nreset                    (nreset),
        .req_early_v_i             (req_early_v),
        .req_ready_v_o             (req_ready_v),
        .req_cancel_i              (req_cancel),
        .req_data_i                (req_data),
        .req_len_i                 (req_len),
        .req_pkt_len_i             (req_pkt_len),
        .req_cs_i                  (req_cs),
        .req_last_i                (req_last),
        .req_last_block_next_i     (req_lbn),
        .req_last_block_next_len_i (req_lbl),
        .app_early_v_o             (app_early_v),
        .app_ready_v_i             (app_ready_v),
        .app_cancel_o              (app_cancel),
        .app_data_o                (app_data),
        .app_len_o                 (app_len),
        .app_pkt_len_o             (app_pkt_len),
        .app_cs_o                  (app_cs),
        .app_last_o                (app_last),
        .app_last_block_next_o     (app_lbn),
        .app_last_block_next_len_o (app_lbl),
        .busy_o                    (busy),
        .grant_id_o                (grant_id)
    );

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void add(
        input logic [1:0] early, input logic ready,
        input logic [1:0] cancel, input logic [1:0] last,
        input logic [1:0] l0, input logic [1:0] l1,
        input logic eb, input logic eg, input logic ee,
        input logic [1:0] er, input logic ec, input int fwd);
        vec_t v;
        v.early = early; v.ready = ready; v.cancel = cancel;
        v.last = last; v.l0 = l0; v.l1 = l1;
        v.eb = eb; v.eg = eg; v.ee = ee; v.er = er; v.ec = ec;
        v.fwd = fwd;
        vecs.push_back(v);
    endfunction

    task automatic drive_src(input int row, input logic [1:0] l0,
                             input logic [1:0] l1);
        logic [15:0] d0, d1;
        d0 = 16'hA000 + 16'(row);
        d1 = 16'hB000 + 16'(row);
        req_data = {d1, d0};
        req_len  = {l1, l0};
        req_cs   = {~d1, ~d0};
        req_lbn  = {d1[0], d0[0]};
        req_lbl  = {d1[3:0], d0[3:0]};
    endtask

    task automatic apply(input vec_t v, input int row);
        beat_t b;
        logic [15:0] pl;
        req_early_v = v.early;
        app_ready_v = v.ready;
        req_cancel  = v.cancel;
        req_last    = v.last;
        drive_src(row, v.l0, v.l1);
        if (v.fwd != 0) begin
            b.data = (v.fwd == 1) ? req_data[15:0] : req_data[31:16];
            b.len  = (v.fwd == 1) ? v.l0 : v.l1;
            b.cs   = ~b.data;
            b.last = (v.fwd == 1) ? v.last[0] : v.last[1];
            b.lbn  = b.data[0];
            b.lbl  = b.data[3:0];
            sb.push_back(b);
        end
        @(negedge clk);
        check($sformatf("busy r%0d", row), 64'(busy), 64'(v.eb));
        if (v.eb)
            check($sformatf("grant r%0d", row), 64'(grant_id), 64'(v.eg));
        check($sformatf("early r%0d", row), 64'(app_early_v), 64'(v.ee));
        check($sformatf("ready r%0d", row), 64'(req_ready_v), 64'(v.er));
        check($sformatf("cancel r%0d", row), 64'(app_cancel), 64'(v.ec));
        if (v.ee) begin
            pl = v.eg ? 16'd40 : 16'd19;
            check($sformatf("pkt_len r%0d", row), 64'(app_pkt_len), 64'(pl));
        end
        if (!v.eb)
            check($sformatf("idle_zero r%0d", row),
                  64'({app_data, app_len, app_cs, app_pkt_len,
                       app_last, app_lbn, app_lbl}), 64'(0));
        if (app_len != 0 || v.fwd != 0) begin
            if (sb.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL beat r%0d: got unexpected len %0d expected none",
                         row, app_len);
            end else begin
                b = sb.pop_front();
                check($sformatf("beat r%0d", row),
                      64'({app_data, app_len, app_cs, app_last, app_lbn, app_lbl}),
                      64'({b.data, b.len, b.cs, b.last, b.lbn, b.lbl}));
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        req_early_v = '0;
        req_cancel  = '0;
        req_last    = '0;
        app_ready_v = 1'b0;
        drive_src(0, 2'd0, 2'd0);
    endtask

    initial begin
        // single source 0, 19 bytes, ready held off 3 cycles
        add(2'b01, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0);
        repeat (3) add(2'b01, 0, 0, 0, 0, 0, 1, 0, 1, 2'b00, 0, 0);
        add(2'b01, 1, 0, 0, 0, 0, 1, 0, 1, 2'b01, 0, 0);
        repeat (9) add(0, 0, 0, 0, 2, 0, 1, 0, 0, 0, 0, 1);
        add(0, 0, 0, 2'b01, 1, 0, 1, 0, 0, 0, 0, 1);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        // source 1 cancels at 3rd beat while source 0 waits
        add(2'b11, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add(2'b11, 1, 0, 0, 0, 0, 1, 1, 1, 2'b10, 0, 0);
        repeat (2) add(2'b01, 0, 0, 0, 0, 2, 1, 1, 0, 0, 0, 2);
        add(2'b01, 0, 2'b10, 0, 0, 2, 1, 1, 0, 0, 1, 2);
        // source 0 granted, then withdraws before ready
        add(2'b01, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add(2'b01, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0);
        add(2'b00, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        // source 1 wins, source 0 noise, cancel+last together
        add(2'b11, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add(2'b11, 1, 0, 0, 0, 0, 1, 1, 1, 2'b10, 0, 0);
        add(2'b01, 0, 2'b01, 2'b01, 2, 2, 1, 1, 0, 0, 0, 2);
        add(2'b01, 0, 0, 0, 1, 2, 1, 1, 0, 0, 0, 2);
        add(2'b01, 0, 2'b10, 2'b10, 2, 1, 1, 1, 0, 0, 1, 2);
        add(2'b01, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add(2'b01, 1, 0, 0, 0, 0, 1, 0, 1, 2'b01, 0, 0);
        add(0, 0, 0, 2'b01, 2, 0, 1, 0, 0, 0, 0, 1);
        // source 1 into DATA with pointer at 1, cut by reset below
        add(2'b10, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add(2'b10, 1, 0, 0, 0, 0, 1, 1, 1, 2'b10, 0, 0);
        add(0, 0, 0, 0, 0, 2, 1, 1, 0, 0, 0, 2);
        mark = vecs.size();
        // after reset both request: pointer back at 0
        add(2'b11, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add(2'b11, 1, 0, 0, 0, 0, 1, 0, 1, 2'b01, 0, 0);
        add(2'b10, 0, 0, 2'b01, 2, 0, 1, 0, 0, 0, 0, 1);
`ifndef ETH_TX_ARB_STRICT_PRIO_EN
        add(2'b11, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add(2'b11, 1, 0, 0, 0, 0, 1, 1, 1, 2'b10, 0, 0);
        add(2'b01, 0, 0, 2'b10, 0, 1, 1, 1, 0, 0, 0, 2);
        add(2'b01, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add(2'b01, 1, 0, 0, 0, 0, 1, 0, 1, 2'b01, 0, 0);
        add(0, 0, 0, 2'b01, 1, 0, 1, 0, 0, 0, 0, 1);
`else
        add(2'b10, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add(2'b10, 1, 0, 0, 0, 0, 1, 1, 1, 2'b10, 0, 0);
        add(0, 0, 0, 2'b10, 0, 1, 1, 1, 0, 0, 0, 2);
`endif
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        req_pkt_len = {16'd40, 16'd19};
        nreset = 1'b0;
        quiet();
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        check("rst busy", 64'(busy), 64'(0));
        check("rst grant", 64'(grant_id), 64'(0));
        check("rst outs", 64'({req_ready_v, app_early_v, app_cancel,
                               app_last, app_len}), 64'(0));
        @(posedge clk);
        #1;
        nreset = 1'b1;

        for (int i = 0; i < mark; i++) apply(vecs[i], i);

        // reset lands while source 1 is streaming
        nreset      = 1'b0;
        req_early_v = '0;
        app_ready_v = 1'b0;
        drive_src(200, 2'd0, 2'd2);
        @(posedge clk);
        #1;
        nreset = 1'b1;
        @(negedge clk);
        check("post_rst busy", 64'(busy), 64'(0));
        check("post_rst grant", 64'(grant_id), 64'(0));
        check("post_rst outs",
              64'({req_ready_v, app_early_v, app_cancel, app_last,
                   app_lbn, app_len, app_lbl}), 64'(0));
        check("post_rst data",
              64'({app_data, app_pkt_len, app_cs}), 64'(0));
        @(posedge clk);
        #1;
        quiet();

        for (int i = mark; i < vecs.size(); i++) apply(vecs[i], i);

        check("sb_empty", 64'(sb.size()), 64'(0));
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
